// File: rtl/pwm_rx.sv
// Differential PWM receiver: frame-aligned high-time measurement per line.
// Optional PWM_RX_GLITCH_FILTER_EN adds a 3-tap majority filter per line.
module pwm_rx #(
    parameter int N       = 8,
    parameter int FRAME   = 256,
    parameter int SILENCE = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pwm_pos,
    input  logic               pwm_neg,
    output logic signed [N:0]  sample,
    output logic               sample_valid,
    output logic               locked,
    output logic               overlap_err
);

    localparam int FW = (FRAME > 1) ? $clog2(FRAME) : 1;
    localparam logic [FW-1:0] LAST = FW'(FRAME - 1);
    localparam logic [7:0] SIL_LAST = 8'(SILENCE - 1);
    localparam logic [N-1:0] MAX = '1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state;
    logic [1:0]    p_sync, n_sync;
    logic          p_s, n_s;
    logic          p_x, n_x;
    logic          p_q, n_q;
    logic [2:0]    warm;
    logic          primed;
    logic          p_rise, n_rise;
    logic [FW-1:0] frame_ctr;
    logic [N-1:0]  pos_cnt, neg_cnt;
    logic [N-1:0]  pos_next, neg_next;
    logic [7:0]    silence_ctr;
    logic          frame_end;

    assign p_s = p_sync[1];
    assign n_s = n_sync[1];

    always_ff @(posedge clk) begin
        if (reset) begin
            p_sync <= '0;
            n_sync <= '0;
        end else begin
            p_sync <= {p_sync[0], pwm_pos};
            n_sync <= {n_sync[0], pwm_neg};
        end
    end

`ifdef PWM_RX_GLITCH_FILTER_EN
    localparam logic [2:0] WARM = 3'd5;

    logic [1:0] p_hist, n_hist;

    always_ff @(posedge clk) begin
        if (reset) begin
            p_hist <= '0;
            n_hist <= '0;
        end else begin
            p_hist <= {p_hist[0], p_s};
            n_hist <= {n_hist[0], n_s};
        end
    end

    assign p_x = (p_s & p_hist[0]) | (p_s & p_hist[1])
               | (p_hist[0] & p_hist[1]);
    assign n_x = (n_s & n_hist[0]) | (n_s & n_hist[1])
               | (n_hist[0] & n_hist[1]);
`else
    localparam logic [2:0] WARM = 3'd3;

    assign p_x = p_s;
    assign n_x = n_s;
`endif

    // Edges count only once the previous sample reflects a real input,
    // so a line already high at reset release is not mistaken for an edge.
    assign primed = (warm == WARM);
    assign p_rise = primed & p_x & ~p_q;
    assign n_rise = primed & n_x & ~n_q;

    assign pos_next  = (pos_cnt == MAX) ? MAX : pos_cnt + N'(p_x);
    assign neg_next  = (neg_cnt == MAX) ? MAX : neg_cnt + N'(n_x);
    assign frame_end = (frame_ctr == LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            p_q  <= 1'b0;
            n_q  <= 1'b0;
            warm <= '0;
        end else begin
            p_q <= p_x;
            n_q <= n_x;
            if (!primed)
                warm <= warm + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            frame_ctr    <= '0;
            pos_cnt      <= '0;
            neg_cnt      <= '0;
            silence_ctr  <= '0;
            sample       <= '0;
            sample_valid <= 1'b0;
            locked       <= 1'b0;
            overlap_err  <= 1'b0;
        end else begin
            sample_valid <= 1'b0;
            case (state)
                IDLE: begin
                    locked      <= 1'b0;
                    frame_ctr   <= '0;
                    pos_cnt     <= '0;
                    neg_cnt     <= '0;
                    silence_ctr <= '0;
                    if (p_rise || n_rise) begin
                        state     <= RUN;
                        locked    <= 1'b1;
                        frame_ctr <= FW'(1);
                        pos_cnt   <= N'(p_x);
                        neg_cnt   <= N'(n_x);
                    end
                end
                RUN: begin
                    if (p_x && n_x)
                        overlap_err <= 1'b1;
                    if (frame_end) begin
                        sample <= $signed({1'b0, pos_next})
                                - $signed({1'b0, neg_next});
                        sample_valid <= 1'b1;
                        frame_ctr    <= '0;
                        pos_cnt      <= '0;
                        neg_cnt      <= '0;
                        if (pos_next == '0 && neg_next == '0) begin
                            if (silence_ctr == SIL_LAST) begin
                                state       <= IDLE;
                                locked      <= 1'b0;
                                silence_ctr <= '0;
                            end else begin
                                silence_ctr <= silence_ctr + 8'd1;
                            end
                        end else begin
                            silence_ctr <= '0;
                        end
                    end else begin
                        frame_ctr <= frame_ctr + FW'(1);
                        pos_cnt   <= pos_next;
                        neg_cnt   <= neg_next;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_rx.sv
// Bench for pwm_rx: waveform segments checked cycle by cycle
// against a frame-window reference computed from the raw input arrays.
module tb_pwm_rx;

    localparam int N       = 8;
    localparam int FRAME   = 256;
    localparam int SILENCE = 4;
    localparam int MAXC    = (1 << N) - 1;
`ifdef PWM_RX_GLITCH_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic pwm_pos = 1'b0;
    logic pwm_neg = 1'b0;
    logic signed [N:0] sample;
    logic sample_valid, locked, overlap_err;

    int checks = 0;
    int errors = 0;

    bit wp[$];
    bit wn[$];
    bit e_v[];
    bit e_l[];
    bit e_o[];
    int e_s[];

    pwm_rx #(.N(N), .FRAME(FRAME), .SILENCE(SILENCE)) dut (
        .clk(clk),
        .reset(reset),
        .pwm_pos(pwm_pos),
        .pwm_neg(pwm_neg),
        .sample(sample),
        .sample_valid(sample_valid),
        .locked(locked),
        .overlap_err(overlap_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic bit maj(input bit a, input bit b, input bit c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Line value as seen by the counter in cycle c (raw delayed by 2).
    function automatic bit xv(input int c, input bit isp);
        int r;
        r = c - 2;
        if (FILT) begin
            if (r < 2) return 1'b0;
            if (isp) return maj(wp[r], wp[r-1], wp[r-2]);
            return maj(wn[r], wn[r-1], wn[r-2]);
        end
        if (r < 0) return 1'b0;
        return isp ? wp[r] : wn[r];
    endfunction

    task automatic build_model();
        int L, c0, sil, pc, nc;
        bit lk, rise;
        L = wp.size();
        e_v = new[L + 1];
        e_l = new[L + 1];
        e_o = new[L + 1];
        e_s = new[L + 1];
        e_v[0] = 0;
        e_l[0] = 0;
        e_o[0] = 0;
        e_s[0] = 0;
        lk = 0;
        c0 = 0;
        sil = 0;
        for (int c = 0; c < L; c++) begin
            e_v[c+1] = 0;
            e_l[c+1] = e_l[c];
            e_o[c+1] = e_o[c];
            e_s[c+1] = e_s[c];
            if (!lk) begin
                rise = 0;
                if ((c - 3) >= (FILT ? 2 : 0))
                    rise = (xv(c, 1) && !xv(c - 1, 1))
                        || (xv(c, 0) && !xv(c - 1, 0));
                if (rise) begin
                    lk = 1;
                    c0 = c;
                    e_l[c+1] = 1;
                end
            end else begin
                if (xv(c, 1) && xv(c, 0))
                    e_o[c+1] = 1;
                if (c == c0 + FRAME - 1) begin
                    pc = 0;
                    nc = 0;
                    for (int k = c0; k <= c; k++) begin
                        pc += int'(xv(k, 1));
                        nc += int'(xv(k, 0));
                    end
                    if (pc > MAXC) pc = MAXC;
                    if (nc > MAXC) nc = MAXC;
                    e_s[c+1] = pc - nc;
                    e_v[c+1] = 1;
                    if (pc == 0 && nc == 0) sil++;
                    else sil = 0;
                    if (sil == SILENCE) begin
                        lk = 0;
                        sil = 0;
                        e_l[c+1] = 0;
                    end else begin
                        c0 = c + 1;
                    end
                end
            end
        end
    endtask

    task automatic add(input bit p, input bit n, input int len);
        for (int i = 0; i < len; i++) begin
            wp.push_back(p);
            wn.push_back(n);
        end
    endtask

    task automatic clear_wave();
        wp.delete();
        wn.delete();
    endtask

    task automatic do_reset(input bit hold_pos);
        @(negedge clk);
        reset = 1'b1;
        pwm_pos = hold_pos;
        pwm_neg = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("rst%0d_valid", i), int'(sample_valid), 0);
            chk($sformatf("rst%0d_locked", i), int'(locked), 0);
            chk($sformatf("rst%0d_ovl", i), int'(overlap_err), 0);
            chk($sformatf("rst%0d_sample", i), int'(sample), 0);
        end
    endtask

    task automatic run_seg(input string name);
        build_model();
        for (int c = 0; c < wp.size(); c++) begin
            @(negedge clk);
            if (c == 0) reset = 1'b0;
            chk($sformatf("%s_c%0d_valid", name, c),
                int'(sample_valid), int'(e_v[c]));
            chk($sformatf("%s_c%0d_locked", name, c),
                int'(locked), int'(e_l[c]));
            chk($sformatf("%s_c%0d_ovl", name, c),
                int'(overlap_err), int'(e_o[c]));
            chk($sformatf("%s_c%0d_sample", name, c),
                int'(sample), e_s[c]);
            pwm_pos = wp[c];
            pwm_neg = wn[c];
        end
    endtask

    task automatic rand_line(input int L, input bit isp);
        bit v;
        int k, len;
        v = 0;
        k = 0;
        while (k < L) begin
            len = $urandom_range(1, v ? 120 : 250);
            for (int i = 0; i < len && k < L; i++) begin
                if (isp) wp[k] = v;
                else wn[k] = v;
                k++;
            end
            v = ~v;
        end
    endtask

    initial begin
        // Lock and +64 per frame
        clear_wave();
        add(0, 0, 10);
        repeat (6) begin
            add(1, 0, 64);
            add(0, 0, 192);
        end
        do_reset(0);
        run_seg("pos64");

        // -200, then pos saturating at full scale
        clear_wave();
        add(0, 0, 5);
        repeat (4) begin
            add(0, 1, 200);
            add(0, 0, 56);
        end
        add(1, 0, 4 * FRAME);
        do_reset(0);
        run_seg("neg_full");

        // Silence unlock, then relock
        clear_wave();
        add(0, 0, 3);
        repeat (2) begin
            add(1, 0, 64);
            add(0, 0, 192);
        end
        add(0, 0, 6 * FRAME);
        add(1, 0, 40);
        add(0, 0, 300);
        do_reset(0);
        run_seg("silence");

        // Overlap: pos 30, neg 10 inside it
        clear_wave();
        add(0, 0, 4);
        repeat (3) begin
            add(1, 0, 10);
            add(1, 1, 10);
            add(1, 0, 10);
            add(0, 0, 226);
        end
        do_reset(0);
        run_seg("overlap");

        // Reset at frame cycle ~100 with pos high at release
        clear_wave();
        add(0, 0, 4);
        add(1, 0, 64);
        add(0, 0, 36);
        do_reset(0);
        run_seg("midframe");
        clear_wave();
        add(1, 0, 20);
        add(0, 0, 10);
        add(1, 0, 64);
        add(0, 0, 192);
        add(1, 0, 64);
        add(0, 0, 300);
        do_reset(1);
        run_seg("high_release");

        // Glitches: isolated pulses and a single-cycle drop
        clear_wave();
        add(0, 0, 5);
        repeat (8) begin
            add(1, 0, 1);
            add(0, 0, 20);
        end
        repeat (3) begin
            add(0, 1, 1);
            add(0, 0, 15);
        end
        add(1, 0, 64);
        add(0, 0, 192);
        add(1, 0, 30);
        add(0, 0, 1);
        add(1, 0, 33);
        add(0, 0, 192);
        add(0, 1, 1);
        add(0, 0, 300);
        do_reset(0);
        run_seg("glitch");

        // Randomized independent run lengths on both lines
        for (int s = 0; s < 4; s++) begin
            int L;
            L = $urandom_range(800, 1600);
            clear_wave();
            add(0, 0, L);
            rand_line(L, 1);
            rand_line(L, 0);
            do_reset(0);
            run_seg($sformatf("rand%0d", s));
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
